// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives the combinational instruction ROM and registers its word into IF/ID (one-cycle fetch latency).
// Backpressure: stall_i freezes the PC and IF/ID registers; only an exception overrides a stall.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter logic [31:0] INT_VEC    = 32'h0000_0004,
  parameter logic [31:0] EXC_VEC    = 32'h0000_0008,
  parameter int          KERNEL_BIT = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        int_req_i,
  input  logic        exc_req_i,
  input  logic [31:0] exc_pc_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic [31:0] epc_o,
  output logic        epc_we_o
);

  localparam logic [31:0] KERNEL_MASK = 32'h1 << KERNEL_BIT;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        int_take;

  // Interrupts wait out kernel mode and never split a branch from its delay slot.
  assign int_take = int_req_i & ~pc_q[KERNEL_BIT] & ~branch_i;

  always_comb begin
    pc_next = pc_q + 32'd4;
    if (exc_req_i) begin
      pc_next = EXC_VEC | KERNEL_MASK;
    end else if (int_take) begin
      pc_next = INT_VEC | KERNEL_MASK;
    end else if (branch_i) begin
      pc_next = branch_target_i;
    end
  end

  assign rom_addr_o = pc_q;
  assign rom_ce_o   = (state_q != S_BOOT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VEC;
      if_pc_o    <= 32'h0;
      if_inst_o  <= 32'h0;
      if_valid_o <= 1'b0;
      epc_o      <= 32'h0;
      epc_we_o   <= 1'b0;
    end else begin
      epc_we_o <= 1'b0;
      if (state_q == S_BOOT) begin
        state_q <= S_RUN;
      end else if (exc_req_i) begin
        // The faulting instruction must not replay, so this beats a stall.
        state_q    <= S_RUN;
        pc_q       <= pc_next;
        if_pc_o    <= pc_q;
        if_inst_o  <= 32'h0;
        if_valid_o <= 1'b0;
        epc_o      <= exc_pc_i + 32'd4;
        epc_we_o   <= 1'b1;
      end else if (stall_i) begin
        state_q <= S_HOLD;
      end else begin
        state_q <= S_RUN;
        pc_q    <= pc_next;
        if_pc_o <= pc_q;
        if (int_take) begin
          // The instruction at pc_q was not fetched; it re-executes on return.
          if_inst_o  <= 32'h0;
          if_valid_o <= 1'b0;
          epc_o      <= pc_q;
          epc_we_o   <= 1'b1;
        end else begin
          if_inst_o  <= rom_data_i;
          if_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule
